// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM state type and source IDs for the interrupt pending unit
package irq_pkg;

    localparam int NUM_SRC = 11;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] IRQ_ID_TIMER   = 4'd0;
    localparam logic [ID_W-1:0] IRQ_ID_KEY0    = 4'd1;
    localparam logic [ID_W-1:0] IRQ_ID_KEY1    = 4'd2;
    localparam logic [ID_W-1:0] IRQ_ID_KEY2    = 4'd3;
    localparam logic [ID_W-1:0] IRQ_ID_KEY3    = 4'd4;
    localparam logic [ID_W-1:0] IRQ_ID_UART_RX = 4'd5;
    localparam logic [ID_W-1:0] IRQ_ID_UART_TX = 4'd6;
    localparam logic [ID_W-1:0] IRQ_ID_GPIO    = 4'd7;
    localparam logic [ID_W-1:0] IRQ_ID_DMA     = 4'd8;
    localparam logic [ID_W-1:0] IRQ_ID_SPI     = 4'd9;
    localparam logic [ID_W-1:0] IRQ_ID_SW      = 4'd10;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder with valid flag
module irq_prio_enc #(
    parameter int NUM_SRC = 11,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_unit.sv
// rtl/irq_pending_unit.sv - sticky pending capture, priority select and req/ack/eret handshake
// Optional level-sensitive sources via macro IRQ_LEVEL_EN (adds parameter LEVEL_MASK).
module irq_pending_unit #(
    parameter int NUM_SRC = irq_pkg::NUM_SRC,
    parameter int ID_W    = irq_pkg::ID_W
`ifdef IRQ_LEVEL_EN
    , parameter logic [NUM_SRC-1:0] LEVEL_MASK = '0
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               gie,
    input  logic               irq_ack,
    input  logic               irq_eret,
    output logic [NUM_SRC-1:0] pend_masked,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [ID_W-1:0]    svc_id
);
    import irq_pkg::*;

`ifdef IRQ_LEVEL_EN
    localparam logic [NUM_SRC-1:0] LVL = LEVEL_MASK;
`else
    localparam logic [NUM_SRC-1:0] LVL = '0;
`endif

    state_t             state;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] id_onehot;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_next;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;
    logic               en_sel;

    assign rise        = irq_src & ~src_q;
    assign pend_masked = pending & irq_en;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (pend_masked),
        .id    (sel_id),
        .valid (sel_valid)
    );

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_onehot[i] = (irq_id == ID_W'(i));
        end
    end

    assign en_sel = |(irq_en & id_onehot);
    assign clr    = (state == REQ && irq_ack) ? (id_onehot & ~LVL) : '0;

    // A new edge in the same cycle as the clearing ack keeps the bit set.
    assign pending_next = (LVL & irq_src) | (~LVL & ((pending & ~clr) | rise));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            src_q      <= '0;
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            svc_id     <= '0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (gie && sel_valid) begin
                        irq_id  <= sel_id;
                        irq_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        svc_id     <= irq_id;
                        irq_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SVC;
                    end else if (!gie || !en_sel) begin
                        irq_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SVC: begin
                    if (irq_eret) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    irq_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_pending_unit.md
Name: irq_pending_unit

Overview:
- Upstream stage of the CPU's 11-input "any interrupt pending" OR reduction.
- Captures 11 interrupt request lines as sticky pending bits and applies enables.
- Selects the highest-priority source and runs a request/ack/ERET handshake with the single-cycle core's control unit.
- Exports the masked pending vector (to the OR reduction), plus the selected ID and the in-service state.

Parameters:
- NUM_SRC, 11, number of request sources; fixed 11 for this CPU, legal range 1..16.
- ID_W, 4, width of source ID; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_src  in  NUM_SRC  raw request lines; synchronous to clk.
- irq_en  in  NUM_SRC  per-source enable mask.
- gie  in  1  global interrupt enable.
- irq_ack  in  1  core accepts the presented request.
- irq_eret  in  1  core executes return-from-interrupt.
- pend_masked  out  NUM_SRC  pending & irq_en; feeds the OR reduction stage.
- irq_req  out  1  request to core.
- irq_id  out  ID_W  ID of the requested source; valid while irq_req=1.
- in_service  out  1  handler active.
- svc_id  out  ID_W  ID of the source in service.

Behaviour:
- Reset values: pending=0, src_q=0, state=IDLE, irq_req=0, irq_id=0, in_service=0, svc_id=0, pend_masked=0.
- Edge detect: src_q registers irq_src; rise[i] = irq_src[i] & ~src_q[i]. A rising edge sets pending[i] on the next clk.
- A held-high line sets pending once only. Re-arming requires a low cycle.
- pend_masked is combinational from registered pending and irq_en.
- Priority: lowest index wins. sel_id = index of lowest set bit of pend_masked.
- FSM IDLE:
  - If gie=1 and pend_masked!=0, go to REQ.
  - Register irq_id=sel_id and assert irq_req. First request is one cycle after pending is set, so an edge to irq_req takes 2 cycles.
- FSM REQ:
  - irq_req held high, irq_id frozen.
  - Higher-priority arrivals do not change irq_id.
  - If irq_ack=1: clear pending[irq_id], svc_id=irq_id, irq_req=0, in_service=1, go to SVC.
  - If gie drops to 0 or en[irq_id] drops to 0 before ack: withdraw (irq_req=0), pending kept, go to IDLE.
- FSM SVC:
  - No new requests; pending keeps accumulating.
  - On irq_eret=1: in_service=0, go to IDLE. Re-arbitration happens the next cycle.
- Simultaneous events:
  - Rising edge on source k in the same cycle the ack clears pending[k]: set wins, pending[k]=1.
  - irq_eret in IDLE or REQ: ignored.
  - irq_ack outside REQ: ignored.
- Disabled sources stay pending and are visible again once re-enabled.
- Asynchronous reset mid-handshake immediately forces all reset values.

Optional Feature:
- Macro IRQ_LEVEL_EN adds parameter LEVEL_MASK (default 0, width NUM_SRC).
- With the macro, for sources where LEVEL_MASK[i]=1:
  - pending[i] tracks irq_src[i] registered each cycle, with no stickiness.
  - Ack does not clear pending[i]. The handler must deassert the source before ERET, otherwise it re-requests.
- Without the macro: all sources are edge-triggered and sticky, and LEVEL_MASK does not exist.

Decomposition:
- Shared package irq_pkg holds:
  - NUM_SRC and ID_W constants;
  - FSM state enum (IDLE, REQ, SVC, 2-bit);
  - fixed source-ID constants (IRQ_ID_TIMER=0, IRQ_ID_KEY0..=1.., etc.) used by both core and bench.
- One sub-module: irq_prio_enc (NUM_SRC-bit one-hot-or-multi to lowest-index ID_W encoder plus valid). It is purely combinational and reused by the core's exception cause mux.

Test Plan:
- Reset then pulse irq_src[3] for 1 cycle with en=all-ones, gie=1:
  - pend_masked=0x008 next cycle;
  - irq_req=1 with irq_id=3 two cycles after the edge;
  - ack: in_service=1, svc_id=3, pend_masked=0.
- Raise irq_src[7] and irq_src[2] in the same cycle: irq_id=2. After ack and ERET, irq_id=7 is requested.
- Source 5 in REQ with irq_id=5, then source 0 edges: irq_id stays 5 until ack. After ERET, 0 is requested.
- Hold irq_src[4] high for 20 cycles across ack and ERET: exactly one request. Drop low then raise: second request.
- irq_en[6]=0 with an edge on 6: pend_masked=0 and no request. Set irq_en[6]=1: request for 6 follows.
- Edge on 9 coincident with its ack: pending[9] remains 1. Assert rst_n=0 during SVC: all outputs 0 asynchronously.
